// File: rtl/audio_pkg.sv
// Shared types and constants for the flash-to-codec sample playback path.
package audio_pkg;

  localparam int unsigned SAMPLE_W         = 16;
  localparam int unsigned DEFAULT_TICK_DIV = 2268;

  typedef enum logic [2:0] {
    StFetch,
    StAck,
    StWaitTick,
    StWrite,
    StFinished
  } player_state_e;

endpackage

// File: rtl/rate_tick.sv
// Sample-rate divider: one-cycle tick every TICK_DIV enabled clock cycles.
module rate_tick import audio_pkg::*; #(
  parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam logic [15:0] LastCnt = 16'(TICK_DIV - 1);

  logic [15:0] cnt_q;
  logic        at_last;

  assign at_last = (cnt_q == LastCnt);

  // Counter freezes while paused so the phase resumes where it stopped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= at_last ? '0 : cnt_q + 16'd1;
    end
  end

  assign tick = enable & at_last;

endmodule

// File: rtl/sample_player.sv
// Pulls samples from the flash reader, paces them with the rate tick and writes them,
// volume-scaled, to both codec channels.
module sample_player import audio_pkg::*; #(
  parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV,
  parameter int unsigned SAMPLE_W = audio_pkg::SAMPLE_W,
  parameter int unsigned CNT_W    = 9
) (
  input  logic                CLOCK_50,
  input  logic                resetb,
  input  logic                enable,
  input  logic [2:0]          volume,
  input  logic [SAMPLE_W-1:0] rd_data,
  input  logic                rd_valid,
  input  logic                rd_done,
  output logic                rd_next,
  input  logic                audio_ready,
  output logic                audio_write,
  output logic [SAMPLE_W-1:0] audio_left,
  output logic [SAMPLE_W-1:0] audio_right,
  output logic [CNT_W-1:0]    played,
  output logic [7:0]          underruns,
  output logic                finished
);

  player_state_e       state_q, state_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic [SAMPLE_W-1:0] out_q, out_d;
  logic [SAMPLE_W-1:0] shifted;
  logic [CNT_W-1:0]    played_q, played_d;
  logic [7:0]          under_q, under_d;
  logic                have_q, have_d;
  logic                last_q, last_d;
  logic                rd_next_q, rd_next_d;
  logic                write_en;
  logic                tick;

  rate_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_rate_tick (
    .clk    (CLOCK_50),
    .rst_n  (resetb),
    .enable (enable),
    .tick   (tick)
  );

  assign shifted = $signed(sample_q) >>> volume;

  always_comb begin
    state_d   = state_q;
    sample_d  = sample_q;
    out_d     = out_q;
    played_d  = played_q;
    under_d   = under_q;
    have_d    = have_q;
    last_d    = last_q;
    rd_next_d = rd_next_q;
    write_en  = 1'b0;

    case (state_q)
      StFetch: begin
        if (rd_valid && !have_q) begin
          sample_d  = rd_data;
          have_d    = 1'b1;
          rd_next_d = 1'b1;
          state_d   = StAck;
        end else if (rd_done && !rd_valid) begin
          state_d = StFinished;
        end
      end
      StAck: begin
        // Reader keeps valid high after its final sample; done marks it as the last one.
        if (rd_done) begin
          rd_next_d = 1'b0;
          last_d    = 1'b1;
          state_d   = StWaitTick;
        end else if (!rd_valid) begin
          rd_next_d = 1'b0;
          state_d   = StWaitTick;
        end
      end
      StWaitTick: begin
        if (tick && have_q) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (enable && audio_ready) begin
          write_en = 1'b1;
          out_d    = shifted;
          have_d   = 1'b0;
          if (played_q != '1) begin
            played_d = played_q + CNT_W'(1);
          end
          state_d = last_q ? StFinished : StFetch;
        end
      end
      StFinished: begin
        rd_next_d = 1'b0;
      end
      default: begin
        state_d = StFetch;
      end
    endcase

    if (tick && !have_q && (state_q == StFetch || state_q == StWaitTick) && under_q != 8'hFF) begin
      under_d = under_q + 8'd1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetb) begin
    if (!resetb) begin
      state_q   <= StFetch;
      sample_q  <= '0;
      out_q     <= '0;
      played_q  <= '0;
      under_q   <= '0;
      have_q    <= 1'b0;
      last_q    <= 1'b0;
      rd_next_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sample_q  <= sample_d;
      out_q     <= out_d;
      played_q  <= played_d;
      under_q   <= under_d;
      have_q    <= have_d;
      last_q    <= last_d;
      rd_next_q <= rd_next_d;
    end
  end

  // The strobe is combinational on audio_ready, so the data bypasses the hold register.
  assign audio_write = write_en;
  assign audio_left  = write_en ? shifted : out_q;
  assign audio_right = audio_left;
  assign rd_next     = rd_next_q;
  assign played      = played_q;
  assign underruns   = under_q;
  assign finished    = (state_q == StFinished);

endmodule

// File: tb/tb_sample_player.sv
// Directed bench for sample_player: reader model, codec write monitor, hand-computed vectors.
module tb_sample_player;

  localparam int unsigned TD = 8;

  logic        CLOCK_50 = 1'b0;
  logic        resetb = 1'b0;
  logic        enable = 1'b1;
  logic [2:0]  volume = 3'd0;
  logic [15:0] rd_data = 16'h0;
  logic        rd_valid = 1'b0;
  logic        rd_done = 1'b0;
  logic        rd_next;
  logic        audio_ready = 1'b1;
  logic        audio_write;
  logic [15:0] audio_left;
  logic [15:0] audio_right;
  logic [8:0]  played;
  logic [7:0]  underruns;
  logic        finished;

  sample_player #(
    .TICK_DIV (TD),
    .SAMPLE_W (16),
    .CNT_W    (9)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .resetb      (resetb),
    .enable      (enable),
    .volume      (volume),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_done     (rd_done),
    .rd_next     (rd_next),
    .audio_ready (audio_ready),
    .audio_write (audio_write),
    .audio_left  (audio_left),
    .audio_right (audio_right),
    .played      (played),
    .underruns   (underruns),
    .finished    (finished)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: outputs sampled on the falling edge, inputs driven 1 time unit after the rising edge.
  int          cyc = 0;
  int          wr_n = 0;
  int          nx_rise = 0;
  int          nx_hi = 0;
  logic        nx_prev = 1'b0;
  logic [15:0] wr_l [64];
  logic [15:0] wr_r [64];
  int          wr_cyc [64];

  always @(negedge CLOCK_50) begin
    cyc     <= cyc + 1;
    nx_prev <= rd_next;
    if (rd_next) nx_hi <= nx_hi + 1;
    if (rd_next && !nx_prev) nx_rise <= nx_rise + 1;
    if (audio_write && wr_n < 64) begin
      wr_l[wr_n]   <= audio_left;
      wr_r[wr_n]   <= audio_right;
      wr_cyc[wr_n] <= cyc;
      wr_n         <= wr_n + 1;
    end
  end

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  logic [15:0] rd_mem [8];
  logic [15:0] exp_v [8];
  logic        rd_abort = 1'b0;
  logic        rd_busy = 1'b0;

  // Flash reader model: present, wait for next, ignore it for ign cycles, then drop valid.
  // After the final sample valid stays high and done rises.
  task automatic reader(input int n, input int ign, input int dly0, input int dly);
    int t;
    rd_busy = 1'b1;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < ((i == 0) ? dly0 : dly) && !rd_abort; k++) step();
      if (rd_abort) break;
      rd_data  = rd_mem[i];
      rd_valid = 1'b1;
      t = 0;
      while (!rd_next && !rd_abort && t < 1000) begin
        step();
        t++;
      end
      if (rd_abort) break;
      if (!rd_next) begin
        check_eq("rd_next_timeout", 32'(rd_next), 32'd1);
        break;
      end
      for (int k = 0; k < ign && !rd_abort; k++) step();
      if (rd_abort) break;
      if (i == n - 1) begin
        rd_done = 1'b1;
      end else begin
        rd_valid = 1'b0;
        rd_data  = 16'h0;
        step();
      end
    end
    rd_busy = 1'b0;
  endtask

  task automatic do_reset();
    rd_abort = 1'b1;
    for (int i = 0; i < 50 && rd_busy; i++) step();
    check_eq("reader_idle", 32'(rd_busy), 32'd0);
    resetb      = 1'b0;
    enable      = 1'b1;
    audio_ready = 1'b1;
    volume      = 3'd0;
    rd_valid    = 1'b0;
    rd_done     = 1'b0;
    rd_data     = 16'h0;
    step();
    step();
    rd_abort = 1'b0;
    resetb   = 1'b1;
  endtask

  task automatic check_stream(input string tag, input int base, input int n);
    check_eq({tag, "_writes"}, 32'(wr_n - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s_left%0d", tag, i), 32'(wr_l[base + i]), 32'(exp_v[i]));
      check_eq($sformatf("%s_right%0d", tag, i), 32'(wr_r[base + i]), 32'(exp_v[i]));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rd_next"}, 32'(rd_next), 32'd0);
    check_eq({tag, "_write"}, 32'(audio_write), 32'd0);
    check_eq({tag, "_left"}, 32'(audio_left), 32'd0);
    check_eq({tag, "_right"}, 32'(audio_right), 32'd0);
    check_eq({tag, "_played"}, 32'(played), 32'd0);
    check_eq({tag, "_underruns"}, 32'(underruns), 32'd0);
    check_eq({tag, "_finished"}, 32'(finished), 32'd0);
  endtask

  int base;
  int nbase;
  int hbase;

  initial begin
    step();
    step();
    check_reset_outputs("por");

    // Three samples at full volume, one write per tick, then stop.
    do_reset();
    base = wr_n; nbase = nx_rise;
    rd_mem[0] = 16'h1234; rd_mem[1] = 16'h8000; rd_mem[2] = 16'h7FFF;
    exp_v[0]  = 16'h1234; exp_v[1]  = 16'h8000; exp_v[2]  = 16'h7FFF;
    fork reader(3, 0, 0, 0); join_none
    repeat (60) step();
    check_stream("t1", base, 3);
    check_eq("t1_gap01", 32'(wr_cyc[base + 1] - wr_cyc[base]), 32'(TD));
    check_eq("t1_gap12", 32'(wr_cyc[base + 2] - wr_cyc[base + 1]), 32'(TD));
    check_eq("t1_played", 32'(played), 32'd3);
    check_eq("t1_finished", 32'(finished), 32'd1);
    check_eq("t1_underruns", 32'(underruns), 32'd0);
    check_eq("t1_captures", 32'(nx_rise - nbase), 32'd3);
    check_eq("t1_rd_next_low", 32'(rd_next), 32'd0);

    // Volume shift keeps the sign.
    do_reset();
    volume = 3'd2;
    base = wr_n;
    rd_mem[0] = 16'h8004; rd_mem[1] = 16'h0007;
    exp_v[0]  = 16'hE001; exp_v[1]  = 16'h0001;
    fork reader(2, 0, 0, 0); join_none
    repeat (40) step();
    check_stream("t2", base, 2);
    check_eq("t2_played", 32'(played), 32'd2);

    // Slow reader holds valid 4 cycles after next: next stays up 5 cycles per sample.
    do_reset();
    base = wr_n; nbase = nx_rise; hbase = nx_hi;
    rd_mem[0] = 16'h0A0A; rd_mem[1] = 16'hB0B0; rd_mem[2] = 16'h0C0C;
    exp_v[0]  = 16'h0A0A; exp_v[1]  = 16'hB0B0; exp_v[2]  = 16'h0C0C;
    fork reader(3, 4, 0, 0); join_none
    repeat (40) step();
    check_stream("t3", base, 3);
    check_eq("t3_captures", 32'(nx_rise - nbase), 32'd3);
    check_eq("t3_next_cycles", 32'(nx_hi - hbase), 32'd15);
    check_eq("t3_played", 32'(played), 32'd3);

    // First sample arrives 3 periods late: ticks 8, 16, 24 find nothing.
    do_reset();
    base = wr_n;
    rd_mem[0] = 16'h1111; rd_mem[1] = 16'h2222; rd_mem[2] = 16'h3333;
    exp_v[0]  = 16'h1111; exp_v[1]  = 16'h2222; exp_v[2]  = 16'h3333;
    fork reader(3, 0, 3 * TD, 0); join_none
    repeat (20) step();
    check_eq("t4_underruns_mid", 32'(underruns), 32'd2);
    repeat (50) step();
    check_stream("t4", base, 3);
    check_eq("t4_underruns", 32'(underruns), 32'd3);
    check_eq("t4_played", 32'(played), 32'd3);
    check_eq("t4_finished", 32'(finished), 32'd1);

    // Codec not ready for 20 cycles in WRITE, then a single strobe.
    do_reset();
    audio_ready = 1'b0;
    base = wr_n;
    rd_mem[0] = 16'h4321;
    exp_v[0]  = 16'h4321;
    fork reader(1, 0, 0, 0); join_none
    repeat (28) step();
    check_eq("t5_stalled_writes", 32'(wr_n - base), 32'd0);
    check_eq("t5_stalled_played", 32'(played), 32'd0);
    audio_ready = 1'b1;
    step();
    check_eq("t5_one_write", 32'(wr_n - base), 32'd1);
    repeat (20) step();
    check_stream("t5", base, 1);
    check_eq("t5_played", 32'(played), 32'd1);
    check_eq("t5_finished", 32'(finished), 32'd1);

    // Pause mid-stream, then reset while stalled in WRITE.
    do_reset();
    base = wr_n;
    rd_mem[0] = 16'h0101; rd_mem[1] = 16'h0202; rd_mem[2] = 16'h0303;
    fork reader(3, 0, 0, 0); join_none
    repeat (10) step();
    check_eq("t6_pre_pause_writes", 32'(wr_n - base), 32'd1);
    enable = 1'b0;
    repeat (50) step();
    check_eq("t6_paused_writes", 32'(wr_n - base), 32'd1);
    check_eq("t6_paused_played", 32'(played), 32'd1);
    check_eq("t6_held_left", 32'(audio_left), 32'h0101);
    enable      = 1'b1;
    audio_ready = 1'b0;
    repeat (10) step();
    check_eq("t6_stalled_writes", 32'(wr_n - base), 32'd1);
    resetb      = 1'b0;
    audio_ready = 1'b1;
    #1;
    check_reset_outputs("t6_rst");
    do_reset();
    rd_data  = 16'h5555;
    rd_valid = 1'b1;
    step();
    check_eq("t6_fetch_after_reset", 32'(rd_next), 32'd1);
    check_eq("t6_played_after_reset", 32'(played), 32'd0);
    rd_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
